// File: rtl/ahb_bram_pkg.sv
// rtl/ahb_bram_pkg.sv - shared AHB encodings and FSM state type for the BRAM controller
package ahb_bram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STALL,
        S_ERR1,
        S_ERR2
    } state_e;

endpackage

// File: rtl/ahb_bram_ctrl_if.sv
// rtl/ahb_bram_ctrl_if.sv - AHB-Lite slave bus plus BRAM port signals for ahb_bram_ctrl
interface ahb_bram_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic                  HREADY;
    logic [31:0]           HWDATA;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;
    logic [ADDR_WIDTH-1:0] bram_addra;
    logic [31:0]           bram_dina;
    logic [3:0]            bram_wea;
    logic [ADDR_WIDTH-1:0] bram_addrb;
    logic [31:0]           bram_doutb;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA, bram_doutb,
        output HREADYOUT, HRESP, HRDATA, bram_addra, bram_dina, bram_wea, bram_addrb
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA, bram_doutb,
        input  HREADYOUT, HRESP, HRDATA, bram_addra, bram_dina, bram_wea, bram_addrb
    );

endinterface

// File: rtl/ahb_bram_lane_dec.sv
// rtl/ahb_bram_lane_dec.sv - HSIZE/HADDR[1:0] to byte-lane strobes and alignment check
module ahb_bram_lane_dec
    import ahb_bram_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] be_o,
    output logic       illegal_o
);

    always_comb begin
        be_o      = 4'b0000;
        illegal_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
            HSIZE_HALF: begin
                be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                illegal_o = addr_lo_i[0];
            end
            HSIZE_WORD: begin
                be_o      = 4'b1111;
                illegal_o = |addr_lo_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// rtl/ahb_bram_ctrl.sv - AHB-Lite slave sequencing a write-port-A / read-port-B byte-enable BRAM
// Optional macro BRAM_RAW_FWD_EN: forward same-word write data instead of stalling a hazard read.
module ahb_bram_ctrl
    import ahb_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_bram_ctrl_if.slave  bus
);

    state_e                state_q, state_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]            wr_be_q, wr_be_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic [3:0]            be;
    logic                  illegal;
    logic [ADDR_WIDTH-1:0] word;
    logic                  can_accept, accept, ok_wr, ok_rd, hazard;
    logic [31:0]           rdata;
    logic                  unused_addr;

    ahb_bram_lane_dec u_lane_dec (
        .size_i    (bus.HSIZE),
        .addr_lo_i (bus.HADDR[1:0]),
        .be_o      (be),
        .illegal_o (illegal)
    );

    assign word        = bus.HADDR[ADDR_WIDTH+1:2];
    assign unused_addr = ^bus.HADDR[31:ADDR_WIDTH+2];

    // New address phases are only taken while the slave itself is driving HREADYOUT high.
    assign can_accept = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign accept     = ~HRESET & bus.HSEL & bus.HTRANS[1] & bus.HREADY & can_accept;
    assign ok_wr      = accept & ~illegal & bus.HWRITE;
    assign ok_rd      = accept & ~illegal & ~bus.HWRITE;
    assign hazard     = ok_rd & wr_pend_q & (wr_addr_q == word);

`ifdef BRAM_RAW_FWD_EN
    logic        fwd_pend_q, fwd_pend_d;
    logic [31:0] fwd_data_q, fwd_data_d;
    logic [3:0]  fwd_be_q, fwd_be_d;

    assign fwd_pend_d = hazard;
    assign fwd_data_d = hazard ? bus.HWDATA : fwd_data_q;
    assign fwd_be_d   = hazard ? wr_be_q : fwd_be_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            fwd_pend_q <= 1'b0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
        end else begin
            fwd_pend_q <= fwd_pend_d;
            fwd_data_q <= fwd_data_d;
            fwd_be_q   <= fwd_be_d;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[8*i +: 8] = (fwd_pend_q && fwd_be_q[i]) ? fwd_data_q[8*i +: 8]
                                                          : bus.bram_doutb[8*i +: 8];
        end
    end
`else
    assign rdata = bus.bram_doutb;
`endif

    always_comb begin
        state_d   = state_q;
        wr_pend_d = ok_wr;
        wr_addr_d = ok_wr ? word : wr_addr_q;
        wr_be_d   = ok_wr ? be : wr_be_q;
        rd_pend_d = ok_rd | (state_q == S_STALL);
        rd_addr_d = ok_rd ? word : rd_addr_q;
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (accept && illegal) begin
                    state_d = S_ERR1;
`ifndef BRAM_RAW_FWD_EN
                end else if (hazard) begin
                    state_d = S_STALL;
`endif
                end
            end
            S_STALL: state_d = S_IDLE;
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= S_IDLE;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_be_q   <= wr_be_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // During STALL the latched read address is re-issued so the committed word comes back.
    assign bus.bram_addrb = ok_rd ? word : rd_addr_q;
    assign bus.bram_addra = wr_addr_q;
    assign bus.bram_wea   = wr_pend_q ? wr_be_q : 4'b0000;
    assign bus.bram_dina  = wr_pend_q ? bus.HWDATA : 32'h0;
    assign bus.HREADYOUT  = (state_q != S_STALL) && (state_q != S_ERR1);
    assign bus.HRESP      = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
    assign bus.HRDATA     = (rd_pend_q && (state_q != S_STALL)) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// tb/tb_ahb_bram_ctrl.sv - directed self-checking bench for ahb_bram_ctrl with a behavioural BRAM
module tb_ahb_bram_ctrl;
    import ahb_bram_pkg::*;

    localparam int AW = 12;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 HCLK = ~HCLK;

    ahb_bram_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    assign bus.HREADY = bus.HREADYOUT;

    // Read-first simple dual-port RAM: port B samples the old word when A writes it.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] doutb_q = '0;
    assign bus.bram_doutb = doutb_q;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE0000 | i;
    end

    always @(posedge HCLK) begin
        doutb_q <= mem[bus.bram_addrb];
        for (int b = 0; b < 4; b++) begin
            if (bus.bram_wea[b]) mem[bus.bram_addra][8*b +: 8] = bus.bram_dina[8*b +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = wr;
        bus.HADDR  = a;
        bus.HSIZE  = sz;
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.HREADYOUT !== 1'b1 && n < 8) begin
            step();
            #2;
            n++;
        end
        if (n == 8) check_eq({tag, "_timeout"}, {31'b0, bus.HREADYOUT}, 32'h1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_ph(1'b0, a, HSIZE_WORD);
        step();
        bus_idle();
        #2;
        wait_ready(tag);
        check_eq(tag, bus.HRDATA, exp);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.HWDATA = '0;
        addr_ph(1'b0, 32'h100, HSIZE_WORD);
        step();
        step();
        #2;
        check_eq("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
        check_eq("rst_hresp", {31'b0, bus.HRESP}, 32'h0);
        check_eq("rst_hrdata", bus.HRDATA, 32'h0);
        check_eq("rst_wea", {28'b0, bus.bram_wea}, 32'h0);
        check_eq("rst_addra", {20'b0, bus.bram_addra}, 32'h0);
        check_eq("rst_addrb", {20'b0, bus.bram_addrb}, 32'h0);
        check_eq("rst_dina", bus.bram_dina, 32'h0);
        step();
        HRESET = 1'b0;
        bus_idle();
        step();

        // write dropped by reset during its data phase
        addr_ph(1'b1, 32'h20, HSIZE_WORD);
        step();
        bus_idle();
        bus.HWDATA = 32'h11112222;
        HRESET = 1'b1;
        #2;
        check_eq("drop_wea", {28'b0, bus.bram_wea}, 32'h0);
        step();
        HRESET = 1'b0;
        bus.HWDATA = '0;
        step();
        do_read("drop_mem", 32'h20, 32'hC0DE0008);

        // reset while a hazard read is stalled
        addr_ph(1'b1, 32'h10, HSIZE_WORD);
        step();
        bus.HWDATA = 32'hAAAA5555;
        addr_ph(1'b0, 32'h10, HSIZE_WORD);
        step();
        bus_idle();
        bus.HWDATA = '0;
        #2;
`ifndef BRAM_RAW_FWD_EN
        check_eq("stall_hreadyout", {31'b0, bus.HREADYOUT}, 32'h0);
`endif
        HRESET = 1'b1;
        #1;
        check_eq("mid_rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
        check_eq("mid_rst_hresp", {31'b0, bus.HRESP}, 32'h0);
        check_eq("mid_rst_wea", {28'b0, bus.bram_wea}, 32'h0);
        check_eq("mid_rst_hrdata", bus.HRDATA, 32'h0);
        step();
        HRESET = 1'b0;
        step();
        do_read("post_rst_read", 32'h10, 32'hAAAA5555);

        // word write then same-word read back-to-back
        addr_ph(1'b1, 32'h100, HSIZE_WORD);
        step();
        bus.HWDATA = 32'hDEADBEEF;
        addr_ph(1'b0, 32'h100, HSIZE_WORD);
        #2;
        check_eq("t2_wea", {28'b0, bus.bram_wea}, 32'hF);
        check_eq("t2_addra", {20'b0, bus.bram_addra}, 32'h40);
        check_eq("t2_dina", bus.bram_dina, 32'hDEADBEEF);
        check_eq("t2_addrb", {20'b0, bus.bram_addrb}, 32'h40);
        check_eq("t2_wr_ready", {31'b0, bus.HREADYOUT}, 32'h1);
        step();
        bus_idle();
        bus.HWDATA = '0;
        #2;
`ifdef BRAM_RAW_FWD_EN
        check_eq("t2_fwd_ready", {31'b0, bus.HREADYOUT}, 32'h1);
        check_eq("t2_fwd_rdata", bus.HRDATA, 32'hDEADBEEF);
        step();
`else
        check_eq("t2_stall_ready", {31'b0, bus.HREADYOUT}, 32'h0);
        check_eq("t2_stall_addrb", {20'b0, bus.bram_addrb}, 32'h40);
        step();
        #2;
        check_eq("t2_post_ready", {31'b0, bus.HREADYOUT}, 32'h1);
        check_eq("t2_rdata", bus.HRDATA, 32'hDEADBEEF);
        step();
`endif

        // byte write, half write, then read of the merged word
        addr_ph(1'b1, 32'h103, HSIZE_BYTE);
        step();
        bus.HWDATA = 32'h55000000;
        addr_ph(1'b1, 32'h100, HSIZE_HALF);
        #2;
        check_eq("t3_byte_wea", {28'b0, bus.bram_wea}, 32'h8);
        check_eq("t3_byte_addra", {20'b0, bus.bram_addra}, 32'h40);
        step();
        bus.HWDATA = 32'h0000A5A5;
        addr_ph(1'b0, 32'h100, HSIZE_WORD);
        #2;
        check_eq("t3_half_wea", {28'b0, bus.bram_wea}, 32'h3);
        check_eq("t3_half_dina", bus.bram_dina, 32'h0000A5A5);
        step();
        bus_idle();
        bus.HWDATA = '0;
        #2;
        wait_ready("t3_read");
        check_eq("t3_rdata", bus.HRDATA, 32'h55ADA5A5);
        step();

        // misaligned word read
        addr_ph(1'b0, 32'h102, HSIZE_WORD);
        step();
        bus_idle();
        #2;
        check_eq("t4a_err1_ready", {31'b0, bus.HREADYOUT}, 32'h0);
        check_eq("t4a_err1_resp", {31'b0, bus.HRESP}, 32'h1);
        check_eq("t4a_err1_wea", {28'b0, bus.bram_wea}, 32'h0);
        check_eq("t4a_err1_rdata", bus.HRDATA, 32'h0);
        step();
        #2;
        check_eq("t4a_err2_ready", {31'b0, bus.HREADYOUT}, 32'h1);
        check_eq("t4a_err2_resp", {31'b0, bus.HRESP}, 32'h1);
        step();
        #2;
        check_eq("t4a_idle_resp", {31'b0, bus.HRESP}, 32'h0);
        step();

        // HSIZE=3 write must not touch memory
        addr_ph(1'b1, 32'h100, 3'd3);
        step();
        bus_idle();
        bus.HWDATA = 32'hFFFFFFFF;
        #2;
        check_eq("t4b_err1_wea", {28'b0, bus.bram_wea}, 32'h0);
        check_eq("t4b_err1_ready", {31'b0, bus.HREADYOUT}, 32'h0);
        check_eq("t4b_err1_resp", {31'b0, bus.HRESP}, 32'h1);
        step();
        bus.HWDATA = '0;
        #2;
        check_eq("t4b_err2_ready", {31'b0, bus.HREADYOUT}, 32'h1);
        check_eq("t4b_err2_resp", {31'b0, bus.HRESP}, 32'h1);
        step();
        do_read("t4b_mem", 32'h100, 32'h55ADA5A5);

        // write then read of a neighbouring word: no stall, old contents
        addr_ph(1'b1, 32'h200, HSIZE_WORD);
        step();
        bus.HWDATA = 32'h12345678;
        addr_ph(1'b0, 32'h204, HSIZE_WORD);
        #2;
        check_eq("t5_addrb", {20'b0, bus.bram_addrb}, 32'h81);
        check_eq("t5_addra", {20'b0, bus.bram_addra}, 32'h80);
        check_eq("t5_wea", {28'b0, bus.bram_wea}, 32'hF);
        step();
        bus_idle();
        bus.HWDATA = '0;
        #2;
        check_eq("t5_ready", {31'b0, bus.HREADYOUT}, 32'h1);
        check_eq("t5_rdata", bus.HRDATA, 32'hC0DE0081);
        step();
        do_read("t5_commit", 32'h200, 32'h12345678);

        // IDLE transfer and deselected write are ignored
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'h300;
        bus.HSIZE  = HSIZE_WORD;
        step();
        bus.HWDATA = 32'hCAFEF00D;
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_NONSEQ;
        #2;
        check_eq("t6_idle_wea", {28'b0, bus.bram_wea}, 32'h0);
        check_eq("t6_idle_ready", {31'b0, bus.HREADYOUT}, 32'h1);
        check_eq("t6_idle_resp", {31'b0, bus.HRESP}, 32'h0);
        step();
        bus_idle();
        #2;
        check_eq("t6_nsel_wea", {28'b0, bus.bram_wea}, 32'h0);
        check_eq("t6_nsel_ready", {31'b0, bus.HREADYOUT}, 32'h1);
        check_eq("t6_nsel_resp", {31'b0, bus.HRESP}, 32'h0);
        bus.HWDATA = '0;
        step();
        do_read("t6_mem", 32'h300, 32'hC0DE00C0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
